// File: rtl/vn_ib_lut_loader.sv
// vn_ib_lut_loader
// Converts a valid/ready stream of quantised VN IB LUT entries into the LUT's
// active-low write port, one entry per cycle, at strictly increasing
// addresses 0..VN_LOAD_CYCLE-1. It reports progress and flags a complete,
// resident table to the layered decoder.
//
// Optional feature: define VN_IB_LOADER_CHECKSUM_EN to build an XOR checksum
// over the streamed image. It is compared against checksum_i, which is
// captured with load_start_i. Without the macro, checksum_i is unused and
// load_err_o is tied low.
//
// Handshake: an entry transfers on a rising edge where entry_valid_i and
// entry_ready_o are both high. entry_ready_o depends only on the FSM state,
// never on entry_valid_i. A source holding valid must keep entry_i stable
// until the transfer happens.
//
// Parameter legality: 1 <= VN_LOAD_CYCLE <= 2**WR_ADDR_BITWIDTH.
module vn_ib_lut_loader #(
    parameter int WR_ADDR_BITWIDTH = 6,
    parameter int WR_BITWIDTH      = 4,
    parameter int VN_LOAD_CYCLE    = 64
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic                        load_start_i,
    input  logic [WR_BITWIDTH-1:0]      checksum_i,
    input  logic [WR_BITWIDTH-1:0]      entry_i,
    input  logic                        entry_valid_i,
    output logic                        entry_ready_o,
    output logic [WR_ADDR_BITWIDTH-1:0] waddr_o,
    output logic [WR_BITWIDTH-1:0]      wdata_o,
    output logic                        wen_o,
    output logic                        load_busy_o,
    output logic                        load_done_o,
    output logic                        lut_ready_o,
    output logic                        load_err_o,
    output logic [1:0]                  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Terminal count. When the table fills the whole address space this is
    // the all-ones value, so the counter never has to reach 2**WIDTH.
    localparam logic [WR_ADDR_BITWIDTH-1:0] CNT_LAST =
        WR_ADDR_BITWIDTH'(VN_LOAD_CYCLE - 1);

    state_e                        state_q, state_d;
    logic [WR_ADDR_BITWIDTH-1:0]   cnt_q, cnt_d;
    logic [WR_ADDR_BITWIDTH-1:0]   waddr_q, waddr_d;
    logic [WR_BITWIDTH-1:0]        wdata_q, wdata_d;
    logic                          wen_q, wen_d;
    logic                          lut_ready_q, lut_ready_d;

    logic                          start_accept;
    logic                          accept;
    logic                          last_accept;

    // Handshake qualifiers shared by the FSM and the datapath
    assign start_accept = (state_q == ST_IDLE) && load_start_i;
    assign accept       = entry_valid_i && entry_ready_o;
    assign last_accept  = accept && (cnt_q == CNT_LAST);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load_start_i) state_d = ST_LOAD;
            ST_LOAD: if (last_accept)  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs: ready/busy in LOAD, single-cycle done pulse in DONE
    always_comb begin
        entry_ready_o = 1'b0;
        load_busy_o   = 1'b0;
        load_done_o   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                entry_ready_o = 1'b1;
                load_busy_o   = 1'b1;
            end
            ST_DONE: load_done_o = 1'b1;
            default: ;
        endcase
    end

    // Write-port and progress datapath; a write strobe lasts exactly one cycle
    always_comb begin
        cnt_d       = cnt_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wen_d       = 1'b1;
        lut_ready_d = lut_ready_q;
        if (start_accept) begin
            cnt_d       = '0;
            lut_ready_d = 1'b0;
        end
        if (accept) begin
            waddr_d = cnt_q;
            wdata_d = entry_i;
            wen_d   = 1'b0;
            // Hold at the terminal value instead of wrapping
            if (!last_accept) cnt_d = cnt_q + 1'b1;
        end
        if (state_q == ST_DONE) lut_ready_d = 1'b1;
    end

    // State and datapath registers; reset wins over any in-flight transfer
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b1;
            lut_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            lut_ready_q <= lut_ready_d;
        end
    end

`ifdef VN_IB_LOADER_CHECKSUM_EN
    logic [WR_BITWIDTH-1:0] acc_q, acc_d;
    logic [WR_BITWIDTH-1:0] chk_q, chk_d;
    logic                   err_q, err_d;

    // Checksum: the last entry is folded into acc on its acceptance edge, so
    // in DONE acc already holds the XOR of the full image
    always_comb begin
        acc_d = acc_q;
        chk_d = chk_q;
        err_d = err_q;
        if (start_accept) begin
            acc_d = '0;
            chk_d = checksum_i;
            err_d = 1'b0;
        end
        if (accept) acc_d = acc_q ^ entry_i;
        if (state_q == ST_DONE) err_d = (acc_q != chk_q);
    end

    // Checksum registers
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            acc_q <= '0;
            chk_q <= '0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            chk_q <= chk_d;
            err_q <= err_d;
        end
    end

    assign load_err_o = err_q;
`else
    logic unused_checksum;
    assign unused_checksum = ^checksum_i;
    assign load_err_o      = 1'b0;
`endif

    assign waddr_o     = waddr_q;
    assign wdata_o     = wdata_q;
    assign wen_o       = wen_q;
    assign lut_ready_o = lut_ready_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vn_ib_lut_loader.sv
// Bench for vn_ib_lut_loader: per-cycle vector table for reset, idle, and
// early-load behaviour, plus full-table load sequences with a write scoreboard.
module tb_vn_ib_lut_loader;

    localparam int AW    = 6;
    localparam int DW    = 4;
    localparam int NLOAD = 64;

    // clock / reset
    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic          rst;
    logic          load_start_i;
    logic [DW-1:0] checksum_i;
    logic [DW-1:0] entry_i;
    logic          entry_valid_i;
    logic          entry_ready_o;
    logic [AW-1:0] waddr_o;
    logic [DW-1:0] wdata_o;
    logic          wen_o;
    logic          load_busy_o;
    logic          load_done_o;
    logic          lut_ready_o;
    logic          load_err_o;
    logic [1:0]    dbg_state_o;

    vn_ib_lut_loader #(
        .WR_ADDR_BITWIDTH(AW),
        .WR_BITWIDTH     (DW),
        .VN_LOAD_CYCLE   (NLOAD)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .load_start_i (load_start_i),
        .checksum_i   (checksum_i),
        .entry_i      (entry_i),
        .entry_valid_i(entry_valid_i),
        .entry_ready_o(entry_ready_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .wen_o        (wen_o),
        .load_busy_o  (load_busy_o),
        .load_done_o  (load_done_o),
        .lut_ready_o  (lut_ready_o),
        .load_err_o   (load_err_o),
        .dbg_state_o  (dbg_state_o)
    );

    // scoreboard
    int              total = 0;
    int              bad   = 0;
    logic [AW+DW-1:0] exp_q[$];
    bit              mon_en = 1'b0;
    int              n_wr, n_done, n_busy;
    bit              done_ok;

    typedef struct packed {
        logic          rst;
        logic          start;
        logic          valid;
        logic [DW-1:0] entry;
        logic [17:0]   exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // expected output vector {state, ready, wen, addr, data, busy, done, lut_ready, err}
    function automatic logic [17:0] ov(input logic [1:0] st, input logic rdy, input logic wen,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                                       input logic busy, input logic done, input logic lut);
        return {st, rdy, wen, a, d, busy, done, lut, 1'b0};
    endfunction

    function automatic logic [17:0] cur_out();
        return {dbg_state_o, entry_ready_o, wen_o, waddr_o, wdata_o,
                load_busy_o, load_done_o, lut_ready_o, load_err_o};
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic v,
                                input logic [DW-1:0] e, input logic [17:0] x);
        vec_t t;
        t.rst = r; t.start = s; t.valid = v; t.entry = e; t.exp = x;
        return t;
    endfunction

    function automatic logic [DW-1:0] ent(input int dmode, input int i);
        case (dmode)
            0:       return DW'(i % 16);
            1:       return 4'h3;
            default: return DW'((i * 7 + 3) % 16);
        endcase
    endfunction

    // advance to the next falling edge and observe the write port
    task automatic tick();
        logic [AW+DW-1:0] e;
        @(negedge sys_clk);
        if (mon_en) begin
            if (!wen_o) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr=%0d data=%0h want no write", waddr_o, wdata_o);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr_data", 32'({waddr_o, wdata_o}), 32'(e));
                end
            end
            if (load_done_o) begin
                n_done++;
                done_ok = !wen_o && (waddr_o == AW'(NLOAD - 1));
            end
            if (load_busy_o) n_busy++;
        end
    endtask

    // driver: one table load; n_stop < NLOAD asserts rst after n_stop acceptances
    task automatic run_load(input bit gap, input bit mid_start, input int dmode,
                            input logic [DW-1:0] chk, input int n_stop);
        logic [DW-1:0] x;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          exp_err;
        int            i;
        int            k;
        n_wr = 0; n_done = 0; n_busy = 0; done_ok = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        x = '0;
        load_start_i  = 1'b1;
        checksum_i    = chk;
        entry_valid_i = 1'b0;
        tick();
        load_start_i = 1'b0;
        check("start_clears_lut_ready", 32'(lut_ready_o), 32'(0));
        check("entry_ready_in_load", 32'(entry_ready_o), 32'(1));
        i = 0;
        k = 0;
        while (i < n_stop) begin
            load_start_i = 1'b0;
            if (gap && k[0]) begin
                entry_valid_i = 1'b0;
            end else begin
                d = ent(dmode, i);
                a = AW'(i);
                entry_valid_i = 1'b1;
                entry_i       = d;
                exp_q.push_back({a, d});
                x = x ^ d;
                load_start_i = mid_start && (i == 10);
                i++;
            end
            k++;
            tick();
        end
        load_start_i = 1'b0;
        if (n_stop < NLOAD) begin
            rst           = 1'b1;
            entry_valid_i = 1'b1;
            entry_i       = 4'hF;
            tick();
            rst           = 1'b0;
            entry_valid_i = 1'b0;
            check("rst_midload_outputs", 32'(cur_out()), 32'(ov(2'd0, 0, 1, 0, 0, 0, 0, 0)));
            tick();
            tick();
            check("rst_midload_writes", 32'(n_wr), 32'(n_stop));
            check("rst_midload_sb_empty", 32'(exp_q.size()), 32'(0));
        end else begin
            entry_valid_i = 1'b0;
            tick();
`ifdef VN_IB_LOADER_CHECKSUM_EN
            exp_err = (x != chk);
`else
            exp_err = 1'b0;
`endif
            check("after_done_outputs",
                  32'({entry_ready_o, wen_o, load_busy_o, load_done_o, lut_ready_o, load_err_o}),
                  32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b1, exp_err}));
            check("write_count", 32'(n_wr), 32'(NLOAD));
            check("done_pulse_count", 32'(n_done), 32'(1));
            check("done_with_last_write", 32'(done_ok), 32'(1));
            check("busy_cycles", 32'(n_busy), 32'(gap ? 2 * NLOAD - 1 : NLOAD));
            check("sb_empty", 32'(exp_q.size()), 32'(0));
        end
        mon_en = 1'b0;
    endtask

    initial begin
        logic [17:0] idle_v;
        rst = 1'b1;
        load_start_i = 1'b0;
        checksum_i = '0;
        entry_i = '0;
        entry_valid_i = 1'b0;

        idle_v = ov(2'd0, 0, 1, 6'd0, 4'h0, 0, 0, 0);
        vecs[0]  = mk(0, 0, 0, 4'h0, idle_v);
        vecs[1]  = mk(0, 0, 0, 4'h0, idle_v);
        vecs[2]  = mk(0, 0, 0, 4'h0, idle_v);
        vecs[3]  = mk(0, 0, 0, 4'h0, idle_v);
        vecs[4]  = mk(0, 0, 0, 4'h0, idle_v);
        vecs[5]  = mk(0, 1, 0, 4'h0, idle_v);
        vecs[6]  = mk(0, 0, 1, 4'h5, ov(2'd1, 1, 1, 6'd0, 4'h0, 1, 0, 0));
        vecs[7]  = mk(0, 0, 1, 4'hA, ov(2'd1, 1, 0, 6'd0, 4'h5, 1, 0, 0));
        vecs[8]  = mk(0, 0, 0, 4'h0, ov(2'd1, 1, 0, 6'd1, 4'hA, 1, 0, 0));
        vecs[9]  = mk(0, 0, 1, 4'h7, ov(2'd1, 1, 1, 6'd1, 4'hA, 1, 0, 0));
        vecs[10] = mk(1, 0, 1, 4'h9, ov(2'd1, 1, 0, 6'd2, 4'h7, 1, 0, 0));
        vecs[11] = mk(0, 0, 0, 4'h0, idle_v);
        vecs[12] = mk(0, 0, 0, 4'h0, idle_v);

        repeat (3) tick();
        for (int r = 0; r < 13; r++) begin
            check($sformatf("vec%0d", r), 32'(cur_out()), 32'(vecs[r].exp));
            rst           = vecs[r].rst;
            load_start_i  = vecs[r].start;
            entry_valid_i = vecs[r].valid;
            entry_i       = vecs[r].entry;
            tick();
        end
        rst = 1'b0;
        load_start_i = 1'b0;
        entry_valid_i = 1'b0;
        tick();

        run_load(1'b0, 1'b0, 0, 4'h0, NLOAD);   // back-to-back 0..63 mod 16
        run_load(1'b1, 1'b0, 2, 4'h5, NLOAD);   // valid toggling 1/0
        run_load(1'b0, 1'b1, 0, 4'h0, NLOAD);   // start pulse ignored at entry 10
        run_load(1'b0, 1'b0, 0, 4'h0, 20);      // rst after 20 acceptances
        run_load(1'b0, 1'b0, 2, 4'h0, NLOAD);   // fresh load restarts at address 0
        run_load(1'b0, 1'b0, 1, 4'h0, NLOAD);   // all 4'h3, checksum matches
        run_load(1'b0, 1'b0, 1, 4'h1, NLOAD);   // all 4'h3, checksum mismatch

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
